mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum consecutive cycles a memory state waits for mem_ready_i.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 opcode_i  input  7  opcode field of the instruction register.
REQ-005 brflag_i  input  1  ALU branch-condition flag.
REQ-006 mem_ready_i  input  1  memory has completed the current request this cycle.
REQ-007 mem_req_o  output  1  memory request strobe.
REQ-008 mem_we_o  output  1  memory write (valid with mem_req_o).
REQ-009 iord_o  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-010 ir_we_o  output  1  instruction register write; datapath also captures the old PC.
REQ-011 pc_we_o  output  1  PC write enable.
REQ-012 pc_src_o  output  1  PC source: 0 = PC+4, 1 = branch target.
REQ-013 alusrc_o  output  1  ALU B select: 0 = rs2, 1 = sign-extended immediate.
REQ-014 alu_op_o  output  2  00 = add, 01 = branch compare, 10 = funct-decoded.
REQ-015 regwrite_o  output  1  register file write enable.
REQ-016 memtoreg_o  output  1  writeback select: 1 = memory data, 0 = ALU result.
REQ-017 fault_o  output  1  controller halted in FAULT.
REQ-018 cause_o  output  2  fault cause: 00 = none, 01 = illegal opcode, 10 = memory timeout.
REQ-019 state_o  output  4  current state encoding.
REQ-020 instret_o  output  32  retired-instruction count.

Function
REQ-021 States and encodings SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, FAULT=9; any other encoding SHALL go to FAULT with cause 01.
REQ-022 Outputs not listed for a state SHALL be 0.
REQ-023 FETCH: mem_req_o=1, iord_o=0; on mem_ready_i=1, ir_we_o=1, pc_we_o=1, pc_src_o=0 in the same cycle, then next state DECODE; otherwise hold.
REQ-024 DECODE (1 cycle) SHALL dispatch on opcode_i:
  - 0000011 (load) or 0100011 (store) -> MEMADR
  - 0110011 or 0010011 -> EXEC
  - 1100011 -> BRANCH
  - any other opcode -> FAULT, cause 01
REQ-025 MEMADR: alusrc_o=1, alu_op_o=00; next state MEMRD for loads, MEMWR for stores.
REQ-026 MEMRD: mem_req_o=1, iord_o=1; on mem_ready_i -> MEMWB.
REQ-027 MEMWB: regwrite_o=1, memtoreg_o=1; next state FETCH.
REQ-028 MEMWR: mem_req_o=1, mem_we_o=1, iord_o=1; on mem_ready_i -> FETCH.
REQ-029 EXEC: alu_op_o=10, alusrc_o=1 only when opcode_i=0010011; next state ALUWB.
REQ-030 ALUWB: regwrite_o=1, memtoreg_o=0; next state FETCH.
REQ-031 BRANCH: alu_op_o=01, alusrc_o=0, pc_src_o=1, pc_we_o=brflag_i; next state FETCH.
REQ-032 mem_req_o and its address/write qualifiers SHALL be held stable until mem_ready_i=1.
REQ-033 Wait counter:
  - cleared on entry to FETCH, MEMRD or MEMWR, and on each mem_ready_i=1
  - incremented each cycle mem_req_o=1 and mem_ready_i=0
  - on reaching WAIT_MAX -> FAULT, cause 10
  - mem_ready_i=1 in that same cycle SHALL take priority over the timeout
REQ-034 instret_o SHALL increment by 1 on the last cycle of each instruction: ALUWB, MEMWB, MEMWR with mem_ready_i=1, and BRANCH.
REQ-035 instret_o SHALL wrap from 0xFFFFFFFF to 0.
REQ-036 FAULT: fault_o=1, cause_o held, all strobes 0; FAULT SHALL only be left via reset.
REQ-037 Strobes SHALL be decoded combinationally from the current state, mem_ready_i and brflag_i; no output lags its state.

Reset
REQ-038 While rst_i=1, regardless of clk_i:
  - state SHALL be FETCH
  - instret_o, the wait counter, fault_o and cause_o SHALL be 0
  - all strobe outputs SHALL be forced to 0
REQ-039 Reset asserted mid-instruction, including mid-memory-wait, SHALL abandon the instruction without retiring it.
REQ-040 After rst_i falls, the controller SHALL start in FETCH with mem_req_o=1.

Verification
REQ-041 R-type 0110011 with mem_ready_i=1 in FETCH -> states 0,1,6,7,0 in 4 cycles; regwrite_o=1 in ALUWB; instret_o=1.
REQ-042 Load with 2 wait cycles in MEMRD -> MEMRD held 3 cycles, then MEMWB with memtoreg_o=1 and regwrite_o=1; instret_o +1.
REQ-043 Branch with brflag_i=1 -> pc_we_o=1 and pc_src_o=1 in BRANCH; with brflag_i=0 -> pc_we_o=0; both return to FETCH.
REQ-044 Opcode 1111111 -> FAULT after DECODE; fault_o=1, cause_o=01, held 20 cycles; rst_i pulse -> state 0, fault_o=0.
REQ-045 mem_ready_i held low 15 cycles in MEMWR -> FAULT, cause_o=10; a variant with ready in cycle 15 -> FETCH, no fault.
REQ-046 rst_i asserted between clock edges during a MEMRD wait -> state_o=0 and all strobes 0 immediately; instret_o=0.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle RISC-V control FSM with memory wait timeout,
// fault capture and retired-instruction counter.
module mc_control #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  opcode_i,
  input  logic        brflag_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        iord_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic        pc_src_o,
  output logic        alusrc_o,
  output logic [1:0]  alu_op_o,
  output logic        regwrite_o,
  output logic        memtoreg_o,
  output logic        fault_o,
  output logic [1:0]  cause_o,
  output logic [3:0]  state_o,
  output logic [31:0] instret_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] FAULT  = 4'd9;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic [3:0]    state_q, state_d;
  logic [1:0]    cause_q, cause_d;
  logic          fault_q;
  logic [CW-1:0] wait_q;
  logic [31:0]   instret_q;
  logic          req_st, timeout, retire;
  logic          is_mem, is_alu, is_br;

  assign req_st  = (state_q == FETCH) ||
                   (state_q == MEMRD) ||
                   (state_q == MEMWR);
  assign timeout = req_st && !mem_ready_i &&
                   (wait_q == CW'(WAIT_MAX - 1));
  assign retire  = (state_q == ALUWB) ||
                   (state_q == MEMWB) ||
                   (state_q == BRANCH) ||
                   ((state_q == MEMWR) && mem_ready_i);

  assign is_mem = (opcode_i == OP_LD) || (opcode_i == OP_ST);
  assign is_alu = (opcode_i == OP_R) || (opcode_i == OP_I);
  assign is_br  = (opcode_i == OP_BR);

  // State, wait counter, fault cause and retire counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      cause_q   <= 2'b00;
      fault_q   <= 1'b0;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      fault_q <= (state_d == FAULT);
      if (mem_ready_i || (state_d != state_q))
        wait_q <= '0;
      else if (req_st)
        wait_q <= wait_q + 1'b1;
      if (retire)
        instret_q <= instret_q + 32'd1;
    end
  end

  // Next-state and fault-cause selection
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      FETCH, MEMRD, MEMWR: begin
        if (mem_ready_i) begin
          if (state_q == FETCH)
            state_d = DECODE;
          else if (state_q == MEMRD)
            state_d = MEMWB;
          else
            state_d = FETCH;
        end else if (timeout) begin
          state_d = FAULT;
          cause_d = 2'b10;
        end
      end
      DECODE: begin
        unique case (1'b1)
          is_mem:  state_d = MEMADR;
          is_alu:  state_d = EXEC;
          is_br:   state_d = BRANCH;
          default: begin
            state_d = FAULT;
            cause_d = 2'b01;
          end
        endcase
      end
      MEMADR:
        state_d = (opcode_i == OP_ST) ? MEMWR : MEMRD;
      MEMWB, ALUWB, BRANCH:
        state_d = FETCH;
      EXEC:
        state_d = ALUWB;
      FAULT:
        state_d = FAULT;
      default: begin
        state_d = FAULT;
        cause_d = 2'b01;
      end
    endcase
  end

  // Strobes decoded from the current state; forced low in reset
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    iord_o     = 1'b0;
    ir_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pc_src_o   = 1'b0;
    alusrc_o   = 1'b0;
    alu_op_o   = 2'b00;
    regwrite_o = 1'b0;
    memtoreg_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        FETCH: begin
          mem_req_o = 1'b1;
          ir_we_o   = mem_ready_i;
          pc_we_o   = mem_ready_i;
        end
        MEMADR: alusrc_o = 1'b1;
        MEMRD: begin
          mem_req_o = 1'b1;
          iord_o    = 1'b1;
        end
        MEMWB: begin
          regwrite_o = 1'b1;
          memtoreg_o = 1'b1;
        end
        MEMWR: begin
          mem_req_o = 1'b1;
          mem_we_o  = 1'b1;
          iord_o    = 1'b1;
        end
        EXEC: begin
          alu_op_o = 2'b10;
          alusrc_o = (opcode_i == OP_I);
        end
        ALUWB: regwrite_o = 1'b1;
        BRANCH: begin
          alu_op_o = 2'b01;
          pc_src_o = 1'b1;
          pc_we_o  = brflag_i;
        end
        default: ;
      endcase
    end
  end

  assign fault_o   = fault_q;
  assign cause_o   = cause_q;
  assign state_o   = state_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: driver queues expected
// cycle outputs, monitor checks them at each falling edge.
module tb_mc_control;

  logic        clk, rst, brf, rdy;
  logic [6:0]  opc;
  logic        mem_req, mem_we, iord, ir_we, pc_we, pc_src;
  logic        alusrc, regwrite, memtoreg, fault;
  logic [1:0]  alu_op, cause;
  logic [3:0]  state;
  logic [31:0] instret;
  logic [10:0] act_outs;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // {req,we,iord,ir_we,pc_we,pc_src,alusrc,alu_op,regwr,m2r}
  localparam logic [10:0] O_NONE = 11'h000;
  localparam logic [10:0] O_FW   = 11'h400;
  localparam logic [10:0] O_FR   = 11'h4C0;
  localparam logic [10:0] O_MA   = 11'h010;
  localparam logic [10:0] O_MR   = 11'h500;
  localparam logic [10:0] O_MWB  = 11'h003;
  localparam logic [10:0] O_MWR  = 11'h700;
  localparam logic [10:0] O_EXR  = 11'h008;
  localparam logic [10:0] O_EXI  = 11'h018;
  localparam logic [10:0] O_AWB  = 11'h002;
  localparam logic [10:0] O_BR1  = 11'h064;
  localparam logic [10:0] O_BR0  = 11'h024;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [10:0] outs;
    logic        flt;
    logic [1:0]  cs;
    logic [31:0] ir;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  mc_control #(.WAIT_MAX(15)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .opcode_i(opc),
    .brflag_i(brf),
    .mem_ready_i(rdy),
    .mem_req_o(mem_req),
    .mem_we_o(mem_we),
    .iord_o(iord),
    .ir_we_o(ir_we),
    .pc_we_o(pc_we),
    .pc_src_o(pc_src),
    .alusrc_o(alusrc),
    .alu_op_o(alu_op),
    .regwrite_o(regwrite),
    .memtoreg_o(memtoreg),
    .fault_o(fault),
    .cause_o(cause),
    .state_o(state),
    .instret_o(instret)
  );

  assign act_outs = {mem_req, mem_we, iord, ir_we, pc_we,
                     pc_src, alusrc, alu_op, regwrite,
                     memtoreg};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic push(input logic [3:0] st,
                      input logic [10:0] o,
                      input logic f, input logic [1:0] c,
                      input logic [31:0] ir,
                      input string nm);
    exp_t e;
    e.name = nm;
    e.st   = st;
    e.outs = o;
    e.flt  = f;
    e.cs   = c;
    e.ir   = ir;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic [6:0] op,
                      input logic br, input logic rd,
                      input logic [3:0] st,
                      input logic [10:0] o,
                      input logic f, input logic [1:0] c,
                      input logic [31:0] ir,
                      input string nm);
    rst = r;
    opc = op;
    brf = br;
    rdy = rd;
    push(st, o, f, c, ir, nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT against the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        m = sb.pop_front();
        checks++;
        if (state !== m.st || act_outs !== m.outs ||
            fault !== m.flt || cause !== m.cs ||
            instret !== m.ir) begin
          errors++;
          $display("FAIL %s: got st=%0d outs=%h flt=%b cause=%b ir=%0d, want st=%0d outs=%h flt=%b cause=%b ir=%0d",
                   m.name, state, act_outs, fault, cause,
                   instret, m.st, m.outs, m.flt, m.cs, m.ir);
        end
      end
    end
  end

  initial begin
    rst = 1;
    opc = OP_R;
    brf = 0;
    rdy = 1;
    @(posedge clk);
    #1;
    step(1, OP_R, 0, 1, 0, O_NONE, 0, 0, 0, "reset0");
    step(1, OP_R, 0, 1, 0, O_NONE, 0, 0, 0, "reset1");

    // R-type
    step(0, OP_R, 0, 1, 0, O_FR,   0, 0, 0, "r_fetch");
    step(0, OP_R, 0, 0, 1, O_NONE, 0, 0, 0, "r_dec");
    step(0, OP_R, 0, 0, 6, O_EXR,  0, 0, 0, "r_exec");
    step(0, OP_R, 0, 0, 7, O_AWB,  0, 0, 0, "r_aluwb");

    // load with two wait cycles
    step(0, OP_LD, 0, 1, 0, O_FR,   0, 0, 1, "ld_fetch");
    step(0, OP_LD, 0, 0, 1, O_NONE, 0, 0, 1, "ld_dec");
    step(0, OP_LD, 0, 0, 2, O_MA,   0, 0, 1, "ld_memadr");
    step(0, OP_LD, 0, 0, 3, O_MR,   0, 0, 1, "ld_wait1");
    step(0, OP_LD, 0, 0, 3, O_MR,   0, 0, 1, "ld_wait2");
    step(0, OP_LD, 0, 1, 3, O_MR,   0, 0, 1, "ld_rdy");
    step(0, OP_LD, 0, 0, 4, O_MWB,  0, 0, 1, "ld_memwb");

    // I-type
    step(0, OP_I, 0, 1, 0, O_FR,   0, 0, 2, "i_fetch");
    step(0, OP_I, 0, 0, 1, O_NONE, 0, 0, 2, "i_dec");
    step(0, OP_I, 0, 0, 6, O_EXI,  0, 0, 2, "i_exec");
    step(0, OP_I, 0, 0, 7, O_AWB,  0, 0, 2, "i_aluwb");

    // branches taken / not taken
    step(0, OP_BR, 1, 0, 0, O_FW,   0, 0, 3, "b_fetch_wait");
    step(0, OP_BR, 1, 1, 0, O_FR,   0, 0, 3, "b1_fetch");
    step(0, OP_BR, 1, 0, 1, O_NONE, 0, 0, 3, "b1_dec");
    step(0, OP_BR, 1, 0, 8, O_BR1,  0, 0, 3, "b1_branch");
    step(0, OP_BR, 0, 1, 0, O_FR,   0, 0, 4, "b0_fetch");
    step(0, OP_BR, 0, 0, 1, O_NONE, 0, 0, 4, "b0_dec");
    step(0, OP_BR, 0, 0, 8, O_BR0,  0, 0, 4, "b0_branch");

    // store, ready arrives in wait cycle 15
    step(0, OP_ST, 0, 1, 0, O_FR,   0, 0, 5, "s_fetch");
    step(0, OP_ST, 0, 0, 1, O_NONE, 0, 0, 5, "s_dec");
    step(0, OP_ST, 0, 0, 2, O_MA,   0, 0, 5, "s_memadr");
    for (int i = 0; i < 14; i++)
      step(0, OP_ST, 0, 0, 5, O_MWR, 0, 0, 5, "s_wait");
    step(0, OP_ST, 0, 1, 5, O_MWR,  0, 0, 5, "s_rdy15");
    step(0, OP_ST, 0, 0, 0, O_FW,   0, 0, 6, "s_back");

    // store timeout
    step(0, OP_ST, 0, 1, 0, O_FR,   0, 0, 6, "t_fetch");
    step(0, OP_ST, 0, 0, 1, O_NONE, 0, 0, 6, "t_dec");
    step(0, OP_ST, 0, 0, 2, O_MA,   0, 0, 6, "t_memadr");
    for (int i = 0; i < 15; i++)
      step(0, OP_ST, 0, 0, 5, O_MWR, 0, 0, 6, "t_wait");
    for (int i = 0; i < 3; i++)
      step(0, OP_ST, 1, 1, 9, O_NONE, 1, 2'b10, 6, "t_fault");
    step(1, OP_ST, 0, 1, 0, O_NONE, 0, 0, 0, "t_rst");

    // illegal opcode
    step(0, OP_BAD, 0, 1, 0, O_FR,   0, 0, 0, "bad_fetch");
    step(0, OP_BAD, 0, 0, 1, O_NONE, 0, 0, 0, "bad_dec");
    for (int i = 0; i < 20; i++)
      step(0, OP_BAD, 0, 1, 9, O_NONE, 1, 2'b01, 0, "bad_fault");
    step(1, OP_R, 0, 1, 0, O_NONE, 0, 0, 0, "bad_rst");

    // reset mid MEMRD wait
    step(0, OP_R,  0, 1, 0, O_FR,   0, 0, 0, "m_r_fetch");
    step(0, OP_R,  0, 0, 1, O_NONE, 0, 0, 0, "m_r_dec");
    step(0, OP_R,  0, 0, 6, O_EXR,  0, 0, 0, "m_r_exec");
    step(0, OP_R,  0, 0, 7, O_AWB,  0, 0, 0, "m_r_aluwb");
    step(0, OP_LD, 0, 1, 0, O_FR,   0, 0, 1, "m_ld_fetch");
    step(0, OP_LD, 0, 0, 1, O_NONE, 0, 0, 1, "m_ld_dec");
    step(0, OP_LD, 0, 0, 2, O_MA,   0, 0, 1, "m_ld_memadr");
    step(0, OP_LD, 0, 0, 3, O_MR,   0, 0, 1, "m_ld_wait");
    rdy = 0;
    #2;
    rst = 1;
    push(0, O_NONE, 0, 0, 0, "m_async_rst");
    @(posedge clk);
    #1;
    step(1, OP_LD, 0, 0, 0, O_NONE, 0, 0, 0, "m_rst_hold");
    step(0, OP_LD, 0, 0, 0, O_FW,   0, 0, 0, "m_post_fetch");

    for (int i = 0; i < 5 && sb.size() > 0; i++)
      @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
